// File: rtl/liteic_pkg.sv
// Shared liteic crossbar constants: slave address map, response codes and
// the read-node FSM state type.
package liteic_pkg;

    localparam int IC_NUM_SLAVE_SLOTS = 2;
    localparam int IC_ARADDR_WIDTH    = 32;

    localparam logic [IC_ARADDR_WIDTH-1:0] IC_SLV_BASE [IC_NUM_SLAVE_SLOTS] =
        '{32'h0000_0000, 32'h0001_0000};
    localparam logic [IC_ARADDR_WIDTH-1:0] IC_SLV_MASK [IC_NUM_SLAVE_SLOTS] =
        '{32'hFFFF_0000, 32'hFFFF_0000};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_R     = 3'd2,
        ST_DECODE_ERR = 3'd3,
        ST_RESP       = 3'd4
    } ic_rd_state_e;

endpackage

// File: rtl/liteic_addr_decoder.sv
// Combinational address decoder: one-hot slave select plus hit flag.
// Overlapping windows resolve to the lowest slave index.
module liteic_addr_decoder
    import liteic_pkg::*;
#(
    parameter int NUM_SLAVES = IC_NUM_SLAVE_SLOTS,
    parameter int ADDR_WIDTH = IC_ARADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SLV_BASE [NUM_SLAVES] = IC_SLV_BASE,
    parameter logic [ADDR_WIDTH-1:0] SLV_MASK [NUM_SLAVES] = IC_SLV_MASK
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr & SLV_MASK[i]) == SLV_BASE[i])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/liteic_master_node_read.sv
// Master-side read node: accepts one AR, routes it to the decoded slave lane,
// returns the lane's response on R. Unmapped addresses complete with DECERR.
module liteic_master_node_read
    import liteic_pkg::*;
#(
    parameter int NUM_SLAVES  = IC_NUM_SLAVE_SLOTS,
    parameter int ADDR_WIDTH  = IC_ARADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = DATA_WIDTH + 2,
    parameter logic [ADDR_WIDTH-1:0] SLV_BASE [NUM_SLAVES] = IC_SLV_BASE,
    parameter logic [ADDR_WIDTH-1:0] SLV_MASK [NUM_SLAVES] = IC_SLV_MASK
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [ADDR_WIDTH-1:0]                  mst_ar_addr_i,
    input  logic [3:0]                             mst_ar_qos_i,
    input  logic                                   mst_ar_valid_i,
    output logic                                   mst_ar_ready_o,
    output logic [DATA_WIDTH-1:0]                  mst_r_data_o,
    output logic [1:0]                             mst_r_resp_o,
    output logic                                   mst_r_valid_o,
    input  logic                                   mst_r_ready_i,
    output logic [ADDR_WIDTH-1:0]                  cbar_reqst_data_o,
    output logic [3:0]                             cbar_reqst_arqos_o,
    output logic [NUM_SLAVES-1:0]                  cbar_reqst_val_o,
    input  logic [NUM_SLAVES-1:0]                  cbar_reqst_rdy_i,
    input  logic [NUM_SLAVES-1:0]                  cbar_resp_val_i,
    output logic [NUM_SLAVES-1:0]                  cbar_resp_rdy_o,
    input  logic [NUM_SLAVES-1:0][RDATA_WIDTH-1:0] cbar_resp_data_i,
    output ic_rd_state_e                           dbg_state_o
);

    // Handshakes: a transfer happens on any rising clk_i where valid and
    // ready are both high; valid is never withdrawn before its ready.

    ic_rd_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [3:0]             qos_q;
    logic [NUM_SLAVES-1:0]  sel_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]             rresp_q;
    logic                   ar_block_q;

    logic [NUM_SLAVES-1:0]  dec_sel;
    logic                   dec_hit;
    logic [RDATA_WIDTH-1:0] resp_word;
    logic                   ar_fire, req_fire, rsp_fire;

    liteic_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr (mst_ar_addr_i),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    always_comb begin
        resp_word = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) resp_word = resp_word | cbar_resp_data_i[i];
        end
    end

    // ar_block_q keeps ar_ready low for the cycle after reset and after an R handshake.
    assign mst_ar_ready_o     = (state_q == ST_IDLE) && !ar_block_q;
    assign ar_fire            = mst_ar_valid_i && mst_ar_ready_o;
    assign req_fire           = |(cbar_reqst_rdy_i & sel_q);
    assign rsp_fire           = |(cbar_resp_val_i & sel_q);
    assign cbar_reqst_val_o   = (state_q == ST_REQ)    ? sel_q : '0;
    assign cbar_resp_rdy_o    = (state_q == ST_WAIT_R) ? sel_q : '0;
    assign cbar_reqst_data_o  = addr_q;
    assign cbar_reqst_arqos_o = qos_q;
    assign mst_r_valid_o      = (state_q == ST_RESP);
    assign mst_r_data_o       = rdata_q;
    assign mst_r_resp_o       = rresp_q;
    assign dbg_state_o        = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (ar_fire) state_d = dec_hit ? ST_REQ : ST_DECODE_ERR;
            ST_REQ:        if (req_fire) state_d = ST_WAIT_R;
            ST_WAIT_R:     if (rsp_fire) state_d = ST_RESP;
            ST_DECODE_ERR: state_d = ST_RESP;
            ST_RESP:       if (mst_r_ready_i) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            qos_q      <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            ar_block_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ar_block_q <= (state_q == ST_RESP) && mst_r_ready_i;
            if (ar_fire) begin
                addr_q <= mst_ar_addr_i;
                qos_q  <= mst_ar_qos_i;
                sel_q  <= dec_sel;
            end
            if (state_q == ST_WAIT_R && rsp_fire) begin
                rdata_q <= resp_word[RDATA_WIDTH-1:2];
                rresp_q <= resp_word[1:0];
            end
            if (state_q == ST_DECODE_ERR) begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_liteic_master_node_read.sv
// Directed bench for liteic_master_node_read with a transaction-level model
// and a per-cycle compare process.
module tb_liteic_master_node_read;
    import liteic_pkg::*;

    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = DW + 2;

    localparam logic [31:0] MAP_BASE [2] = '{32'h0000_0000, 32'h0001_0000};
    localparam logic [31:0] MAP_MASK [2] = '{32'hFFFF_0000, 32'hFFFF_0000};

    logic               clk = 1'b0;
    logic               rst;
    logic [AW-1:0]      ar_addr;
    logic [3:0]         ar_qos;
    logic               ar_valid;
    logic               ar_ready;
    logic [DW-1:0]      r_data;
    logic [1:0]         r_resp;
    logic               r_valid;
    logic               r_ready;
    logic [AW-1:0]      req_data;
    logic [3:0]         req_qos;
    logic [NS-1:0]      req_val;
    logic [NS-1:0]      req_rdy;
    logic [NS-1:0]      rsp_val;
    logic [NS-1:0]      rsp_rdy;
    logic [NS-1:0][RW-1:0] rsp_data;
    ic_rd_state_e       dbg_state;

    always #5 clk = ~clk;

    liteic_master_node_read dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mst_ar_addr_i      (ar_addr),
        .mst_ar_qos_i       (ar_qos),
        .mst_ar_valid_i     (ar_valid),
        .mst_ar_ready_o     (ar_ready),
        .mst_r_data_o       (r_data),
        .mst_r_resp_o       (r_resp),
        .mst_r_valid_o      (r_valid),
        .mst_r_ready_i      (r_ready),
        .cbar_reqst_data_o  (req_data),
        .cbar_reqst_arqos_o (req_qos),
        .cbar_reqst_val_o   (req_val),
        .cbar_reqst_rdy_i   (req_rdy),
        .cbar_resp_val_i    (rsp_val),
        .cbar_resp_rdy_o    (rsp_rdy),
        .cbar_resp_data_i   (rsp_data),
        .dbg_state_o        (dbg_state)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    qos;
        int            lane;
    } req_t;

    req_t           req_q[$];
    logic [RW-1:0]  exp_q[$];
    int             wait_lane = -1;
    int             m_lane;

    function automatic int model_lane(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: requests expected on the crossbar, responses expected on R.
    always @(negedge clk) begin
        if (rst) begin
            req_q.delete();
            exp_q.delete();
            wait_lane = -1;
        end else begin
            chk("lane_exclusive", {62'd0, ($onehot0(req_val) && $onehot0(rsp_rdy)),
                                   !(|req_val && |rsp_rdy)}, 64'd3);
            if (ar_valid && ar_ready) begin
                m_lane = model_lane(ar_addr);
                if (m_lane >= 0) req_q.push_back('{addr: ar_addr, qos: ar_qos, lane: m_lane});
                else             exp_q.push_back({32'h0, 2'b11});
            end
            if (|req_val) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {62'd0, req_val}, 64'd0);
                end else begin
                    chk("req_lane", {62'd0, req_val}, 64'd1 << req_q[0].lane);
                    chk("req_addr", {32'd0, req_data}, {32'd0, req_q[0].addr});
                    chk("req_qos", {60'd0, req_qos}, {60'd0, req_q[0].qos});
                    if (|(req_val & req_rdy)) begin
                        wait_lane = req_q[0].lane;
                        req_q.pop_front();
                    end
                end
            end
            if (|rsp_rdy) begin
                if (wait_lane < 0) begin
                    chk("unexpected_rsp_rdy", {62'd0, rsp_rdy}, 64'd0);
                end else begin
                    chk("rsp_lane", {62'd0, rsp_rdy}, 64'd1 << wait_lane);
                    if (|(rsp_rdy & rsp_val & (NS'(1) << wait_lane))) begin
                        exp_q.push_back(rsp_data[wait_lane]);
                        wait_lane = -1;
                    end
                end
            end
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_r", 64'd1, 64'd0);
                end else begin
                    chk("r_word", {30'd0, r_data, r_resp}, {30'd0, exp_q[0]});
                    if (r_ready) exp_q.pop_front();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar_ready(input string name);
        int n = 0;
        while (!ar_ready && n < 20) begin
            step();
            n++;
        end
        if (!ar_ready) chk(name, 64'd0, 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] q, input logic [RW-1:0] word);
        int n;
        int lane;
        lane     = model_lane(a);
        ar_addr  = a;
        ar_qos   = q;
        ar_valid = 1'b1;
        wait_ar_ready("rd_ar_timeout");
        step();
        ar_valid = 1'b0;
        n = 0;
        while (req_val == '0 && !r_valid && n < 20) begin
            step();
            n++;
        end
        if (|req_val && lane >= 0) begin
            repeat ($urandom_range(0, 2)) step();
            req_rdy = '1;
            step();
            req_rdy = '0;
            rsp_data[lane]     = word;
            rsp_data[1 - lane] = ~word;
            rsp_val            = '1;
            step();
            rsp_val = '0;
        end
        n = 0;
        while (!r_valid && n < 20) begin
            step();
            n++;
        end
        if (!r_valid) chk("rd_r_timeout", 64'd0, 64'd1);
        repeat ($urandom_range(0, 2)) step();
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
    endtask

    logic [31:0] tbl_addr [6] = '{32'h0000_0000, 32'h0000_FFFC, 32'h0001_FFFC,
                                  32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000};

    initial begin
        rst      = 1'b1;
        ar_addr  = '0;
        ar_qos   = '0;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        req_rdy  = '0;
        rsp_val  = '0;
        rsp_data = '0;
        step();
        step();
        chk("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
        chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_r_data", {32'd0, r_data}, 64'd0);
        chk("rst_r_resp", {62'd0, r_resp}, 64'd0);
        chk("rst_req_val", {62'd0, req_val}, 64'd0);
        chk("rst_rsp_rdy", {62'd0, rsp_rdy}, 64'd0);
        rst = 1'b0;

        // Read to slave 1 with a stalled request lane and a stray lane-0 response.
        ar_addr  = 32'h0001_0040;
        ar_qos   = 4'd5;
        ar_valid = 1'b1;
        wait_ar_ready("t1_ar_timeout");
        step();
        ar_valid = 1'b0;
        chk("t1_req_val", {62'd0, req_val}, 64'h2);
        chk("t1_req_addr", {32'd0, req_data}, 64'h0001_0040);
        chk("t1_req_qos", {60'd0, req_qos}, 64'd5);
        chk("t1_ar_ready_busy", {63'd0, ar_ready}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_req_hold_val", {62'd0, req_val}, 64'h2);
            chk("t1_req_hold_addr", {32'd0, req_data}, 64'h0001_0040);
        end
        req_rdy = 2'b10;
        step();
        req_rdy = '0;
        chk("t1_req_drop", {62'd0, req_val}, 64'd0);
        chk("t1_rsp_rdy", {62'd0, rsp_rdy}, 64'h2);
        rsp_data[0] = {32'h1111_2222, 2'b00};
        rsp_data[1] = {32'hDEAD_BEEF, 2'b00};
        rsp_val     = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_stray_r_valid", {63'd0, r_valid}, 64'd0);
            chk("t1_stray_rsp_rdy", {62'd0, rsp_rdy}, 64'h2);
        end
        rsp_val = 2'b10;
        step();
        rsp_val = '0;
        chk("t1_r_valid", {63'd0, r_valid}, 64'd1);
        chk("t1_r_data", {32'd0, r_data}, 64'hDEAD_BEEF);
        chk("t1_r_resp", {62'd0, r_resp}, 64'd0);

        // R backpressure with a second AR waiting.
        ar_addr  = 32'h0000_1234;
        ar_qos   = 4'd3;
        ar_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_ar_ready_held", {63'd0, ar_ready}, 64'd0);
            chk("t4_r_data_stable", {32'd0, r_data}, 64'hDEAD_BEEF);
            chk("t4_r_valid_held", {63'd0, r_valid}, 64'd1);
        end
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk("t4_r_valid_drop", {63'd0, r_valid}, 64'd0);
        chk("t4_ar_ready_gap", {63'd0, ar_ready}, 64'd0);
        step();
        chk("t4_ar_ready_back", {63'd0, ar_ready}, 64'd1);
        step();
        ar_valid = 1'b0;
        chk("t4_req_val", {62'd0, req_val}, 64'h1);
        chk("t4_req_addr", {32'd0, req_data}, 64'h0000_1234);
        chk("t4_req_qos", {60'd0, req_qos}, 64'd3);
        req_rdy = 2'b01;
        step();
        req_rdy     = '0;
        rsp_data[0] = {32'hCAFE_0001, 2'b10};
        rsp_data[1] = {32'h0BAD_0BAD, 2'b00};
        rsp_val     = 2'b01;
        step();
        rsp_val = '0;
        chk("t4_r_data", {32'd0, r_data}, 64'hCAFE_0001);
        chk("t4_r_resp", {62'd0, r_resp}, 64'd2);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;

        // Unmapped address completes locally with DECERR.
        ar_addr  = 32'h0005_0000;
        ar_qos   = 4'd7;
        ar_valid = 1'b1;
        wait_ar_ready("t2_ar_timeout");
        step();
        ar_valid = 1'b0;
        chk("t2_no_req", {62'd0, req_val}, 64'd0);
        chk("t2_r_valid_early", {63'd0, r_valid}, 64'd0);
        step();
        chk("t2_r_valid", {63'd0, r_valid}, 64'd1);
        chk("t2_r_data", {32'd0, r_data}, 64'd0);
        chk("t2_r_resp", {62'd0, r_resp}, 64'd3);
        chk("t2_no_req_late", {62'd0, req_val}, 64'd0);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;

        // Window edges and unmapped corners.
        for (int i = 0; i < 6; i++) begin
            do_read(tbl_addr[i], 4'(i + 8), {tbl_addr[i] ^ 32'hA5A5_5A5A, 2'(i)});
        end

        // Reset while waiting for a response, then a normal read.
        ar_addr  = 32'h0001_0008;
        ar_qos   = 4'd9;
        ar_valid = 1'b1;
        wait_ar_ready("t6_ar_timeout");
        step();
        ar_valid = 1'b0;
        req_rdy  = 2'b10;
        step();
        req_rdy = '0;
        chk("t6_rsp_rdy", {62'd0, rsp_rdy}, 64'h2);
        rst = 1'b1;
        step();
        chk("t6_ar_ready", {63'd0, ar_ready}, 64'd0);
        chk("t6_req_val", {62'd0, req_val}, 64'd0);
        chk("t6_rsp_rdy_clr", {62'd0, rsp_rdy}, 64'd0);
        chk("t6_r_valid", {63'd0, r_valid}, 64'd0);
        chk("t6_r_data", {32'd0, r_data}, 64'd0);
        chk("t6_r_resp", {62'd0, r_resp}, 64'd0);
        chk("t6_req_addr", {32'd0, req_data}, 64'd0);
        chk("t6_req_qos", {60'd0, req_qos}, 64'd0);
        rst = 1'b0;
        step();
        do_read(32'h0000_0010, 4'd1, {32'h7654_3210, 2'b00});
        do_read(32'h0001_0020, 4'd2, {32'h0F0F_F0F0, 2'b01});

        step();
        step();
        chk("end_req_q_empty", 64'(req_q.size()), 64'd0);
        chk("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/liteic_master_node_read.md
Name: liteic_master_node_read

Overview:
Master-side read node of the liteic crossbar, directly upstream of each slave read node. It accepts one AXI-lite AR request from its master port, decodes the address to a slave index, and presents the request on that slave's crossbar request lane. It then collects the read response from the same lane and returns it on the master R channel. Unmapped addresses complete locally with DECERR. There is exactly one outstanding read per master.

Parameters:
NUM_SLAVES, IC_NUM_SLAVE_SLOTS (package), number of slave read nodes on the crossbar
ADDR_WIDTH, IC_ARADDR_WIDTH (package), AR address width
DATA_WIDTH, 32, AXI-lite read data width
RDATA_WIDTH, DATA_WIDTH+2, crossbar response word width; packing is {r_data, r_resp}
SLV_BASE, IC_SLV_BASE (package), per-slave base address array [NUM_SLAVES]
SLV_MASK, IC_SLV_MASK (package), per-slave address mask array [NUM_SLAVES]

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mst_ar_addr_i  in  ADDR_WIDTH  master read address
mst_ar_qos_i  in  4  master AR QoS
mst_ar_valid_i  in  1  AR valid
mst_ar_ready_o  out  1  AR ready
mst_r_data_o  out  DATA_WIDTH  read data
mst_r_resp_o  out  2  read response
mst_r_valid_o  out  1  R valid
mst_r_ready_i  in  1  R ready
cbar_reqst_data_o  out  ADDR_WIDTH  address toward slave nodes, shared by all lanes
cbar_reqst_arqos_o  out  4  QoS toward slave nodes
cbar_reqst_val_o  out  NUM_SLAVES  one-hot request valid
cbar_reqst_rdy_i  in  NUM_SLAVES  per-slave request ready
cbar_resp_val_i  in  NUM_SLAVES  per-slave response valid
cbar_resp_rdy_o  out  NUM_SLAVES  one-hot response ready
cbar_resp_data_i  in  RDATA_WIDTH x NUM_SLAVES  per-slave response words

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: FSM = IDLE, mst_ar_ready_o=0, mst_r_valid_o=0, mst_r_data_o=0, mst_r_resp_o=0, cbar_reqst_val_o=0, cbar_resp_rdy_o=0. All address, QoS, slave-select and response registers clear to 0.
- Decode: hit[i] = ((addr & SLV_MASK[i]) == SLV_BASE[i]). The lowest hit index wins. No hit means DECERR.
- FSM states:
  - IDLE: mst_ar_ready_o=1, driven combinationally from state. On ar_valid & ar_ready, register addr, qos and one-hot sel. Go to REQ if a slave hit, otherwise DECODE_ERR.
  - REQ: cbar_reqst_val_o = sel_onehot. Address and QoS are held stable from registers. When (cbar_reqst_rdy_i & sel_onehot) != 0, the handshake completes that cycle; val drops next cycle and the FSM goes to WAIT_R. The request stays asserted indefinitely until ready; it is never withdrawn.
  - WAIT_R: cbar_resp_rdy_o = sel_onehot. When (cbar_resp_val_i & sel_onehot) != 0, capture cbar_resp_data_i[sel] into mst_r_data_o/mst_r_resp_o and go to RESP. Valid bits from unselected lanes are ignored.
  - DECODE_ERR: load r_data=0 and r_resp=2'b11, then go to RESP. This takes one cycle.
  - RESP: mst_r_valid_o=1, data held stable. On mst_r_ready_i go to IDLE.
- Latency: AR accept to cbar request valid is 1 cycle. Crossbar response handshake to mst_r_valid_o is 1 cycle (registered). DECERR: AR accept to r_valid is 2 cycles.
- A new AR is never accepted before the current R handshake completes. ar_ready is 0 in the cycle after the R handshake, while the FSM is returning to IDLE.
- At most one bit of cbar_reqst_val_o and at most one bit of cbar_resp_rdy_o is set at any time. They are never set simultaneously.
- Reset asserted mid-transaction: return to IDLE next edge with all outputs at reset values. Any in-flight slave-node transaction is abandoned; global reset is assumed to clear slave nodes too.
- AR inputs may change freely while ar_ready=0. Only the captured values are used.

Decomposition:
- liteic_pkg: IC_NUM_SLAVE_SLOTS, IC_SLV_BASE/IC_SLV_MASK arrays, resp encodings (RESP_OKAY=2'b00, RESP_DECERR=2'b11), and an FSM state enum typedef.
- One sub-module, liteic_addr_decoder: combinational address to one-hot sel plus hit flag, using lowest-index priority. It is reusable by the write-path node.

Test Plan:
- Map slave0 base 0x0000_0000 mask 0xFFFF_0000 and slave1 base 0x0001_0000. Read 0x0001_0040 with qos=5 -> cbar_reqst_val_o=2'b10, cbar_reqst_data_o=0x0001_0040, arqos=5; respond {0xDEADBEEF,2'b00} -> mst_r_data_o=0xDEADBEEF, resp=OKAY, 1 cycle after the response handshake.
- Read 0x0005_0000 (unmapped) -> no cbar_reqst_val_o ever set; r_valid 2 cycles after AR accept with resp=2'b11 and data=0.
- Hold cbar_reqst_rdy_i=0 for 10 cycles, then pulse it -> val stays 1 and the address stays stable throughout; val drops the cycle after ready.
- Hold mst_r_ready_i=0 for 5 cycles during RESP -> data stable, ar_ready=0; a second AR presented meanwhile is accepted only after the R handshake.
- Assert cbar_resp_val_i on unselected lane 0 during WAIT_R on slave1 -> ignored; cbar_resp_rdy_o=2'b10 only.
- Assert rst_i during WAIT_R -> next cycle all outputs are at reset values; a subsequent read completes normally.
